// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign-corrected on the final step.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state, w_state_nx;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_hi, r_lo, r_opb, r_result;
    logic            r_neg, r_rneg;
    logic [CW-1:0]   r_cnt;

    // Accept-time decode
    logic            w_accept, w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_bzero, w_ovf, w_special, w_fast, w_last;
    logic [XLEN-1:0] w_ma, w_mb, w_spec_res, w_fres;
    logic [2*XLEN-1:0] w_fprod, w_fsig;

    assign w_accept   = in_valid & (r_state == S_IDLE) & ~flush;
    assign w_a_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    assign w_b_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    assign w_sa       = w_a_signed & a[XLEN-1];
    assign w_sb       = w_b_signed & b[XLEN-1];
    assign w_ma       = w_sa ? -a : a;
    assign w_mb       = w_sb ? -b : b;

    assign w_bzero    = (b == '0);
    assign w_ovf      = ((op == 3'b100) | (op == 3'b110)) & (a == MIN_V) & (b == '1);
    assign w_special  = op[2] & (w_bzero | w_ovf);
    // op[1] selects remainder for the divide group
    assign w_spec_res = w_bzero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign w_fast     = MUL_FAST & ~op[2];

    assign w_fprod = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
    assign w_fsig  = (w_sa ^ w_sb) ? -w_fprod : w_fprod;
    assign w_fres  = (op[1:0] == 2'b00) ? w_fsig[XLEN-1:0] : w_fsig[2*XLEN-1:XLEN];

    // One iteration step; r_hi:r_lo is product (mul) or remainder:dividend/quotient (div)
    logic [XLEN:0]   w_sum, w_shift, w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_hi_nx, w_lo_nx, w_quo, w_rem, w_calc_res;
    logic [2*XLEN-1:0] w_prod, w_psig;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    assign w_diff  = w_shift - {1'b0, r_opb};

    assign w_hi_nx = r_op[2] ? (w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]) : w_sum[XLEN:1];
    assign w_lo_nx = r_op[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};

    assign w_prod  = {w_hi_nx, w_lo_nx};
    assign w_psig  = r_neg ? -w_prod : w_prod;
    assign w_quo   = r_neg ? -w_lo_nx : w_lo_nx;
    assign w_rem   = r_rneg ? -w_hi_nx : w_hi_nx;

    always_comb begin
        w_calc_res = '0;
        if (r_op[2])
            w_calc_res = r_op[1] ? w_rem : w_quo;
        else if (r_op[1:0] == 2'b00)
            w_calc_res = w_psig[XLEN-1:0];
        else
            w_calc_res = w_psig[2*XLEN-1:XLEN];
    end

    assign w_last = (r_cnt == CW'(XLEN-1));

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nx = (w_special | w_fast) ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_state_nx = S_DONE;
            S_DONE: if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (flush) w_state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_op   <= op;
                r_hi   <= '0;
                r_lo   <= w_ma;
                r_opb  <= w_mb;
                r_neg  <= w_sa ^ w_sb;
                r_rneg <= w_sa;
                r_cnt  <= '0;
                if (w_special)
                    r_result <= w_spec_res;
                else if (w_fast)
                    r_result <= w_fres;
            end else if (r_state == S_CALC && !flush) begin
                r_hi  <= w_hi_nx;
                r_lo  <= w_lo_nx;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) r_result <= w_calc_res;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit (XLEN=32, iterative multiply),
// checked against a plain-arithmetic RISC-V M reference.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN_V = 32'h8000_0000;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0, result;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .MUL_FAST(1'b0)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      ux = longint'({32'b0, x});
        longint      uy = longint'({32'b0, y});
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (f)
            3'd0: begin p = ux * uy; r = p[31:0]; end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            3'd4: if (y == 0) r = '1; else if (x == MIN_V && y == '1) r = x; else r = $signed(x) / $signed(y);
            3'd5: if (y == 0) r = '1; else r = x / y;
            3'd6: if (y == 0) r = x; else if (x == MIN_V && y == '1) r = '0; else r = $signed(x) % $signed(y);
            default: if (y == 0) r = x; else r = x % y;
        endcase
        return r;
    endfunction

    // Edges after the accept edge until out_valid: 0 for one-cycle specials, XLEN otherwise
    function automatic int ref_edges(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || ((f == 3'd4 || f == 3'd6) && x == MIN_V && y == '1))) return 0;
        return XLEN;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int hold);
        int edges;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; op = f; a = x; b = y;
        @(posedge clk); #1;
        // keep requesting with junk while busy: must be ignored
        op = 3'($urandom); a = $urandom; b = $urandom;
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_lat"}, edges, ref_edges(f, x, y));
        chk({tag, "_res"}, result, exp);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {out_valid, in_ready, result}, {2'b10, exp});
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk({tag, "_rel"}, {out_valid, busy, in_ready}, 3'b001);
    endtask

    logic [2:0]  dv_op [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] dv_a  [11] = '{32'd7, MIN_V, '1, '1, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
                                32'd5, 32'd5, MIN_V, MIN_V};
    logic [31:0] dv_b  [11] = '{32'hFFFF_FFFD, MIN_V, '1, '1, 32'd2, 32'd2, 32'd3, 32'd0, 32'd0, '1, '1};
    logic [31:0] dv_r  [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'h5555_5554, 32'hFFFF_FFFF, 32'd5, MIN_V, 32'd0};

    initial begin
        logic [2:0]  f;
        logic [31:0] x, y, last;
        bit          seen;

        #2;
        chk("reset", {out_valid, busy, in_ready, result}, {3'b001, 32'd0});
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op($sformatf("dir%0d", i), dv_op[i], dv_a[i], dv_b[i], dv_r[i], 0);

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            x = $urandom; y = $urandom;
            case ($urandom_range(7))
                0: y = '0;
                1: begin x = MIN_V; y = '1; end
                2: begin x = $urandom_range(100); y = 32'($urandom_range(9)) - 32'd4; end
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), f, x, y, ref_md(f, x, y), 0);
        end

        run_op("bp", 3'd5, 32'd1000, 32'd7, 32'd142, 10);
        run_op("bp_next", 3'd7, 32'd1000, 32'd7, 32'd6, 0);
        last = 32'd6;

        // flush at cnt=10 of a DIVU
        @(negedge clk);
        in_valid = 1'b1; op = 3'd5; a = 32'd123456; b = 32'd11;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_state", {out_valid, busy, in_ready}, 3'b001);
        chk("flush_res", result, last);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
        chk("flush_no_valid", seen, 0);

        // flush beats a same-cycle request
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_req", {busy, in_ready}, 2'b01);

        // async reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk("rst_mid", {out_valid, busy, in_ready, result}, {3'b001, 32'd0});
        @(negedge clk); rstn = 1'b1;
        run_op("post_rst", 3'd6, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FFFA, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
